// File: rtl/reorder_buffer_mc_pkg.sv
// Shared opcode codes, widths and opcode-class helpers for the reorder buffer slice.
package reorder_buffer_mc_pkg;

  localparam int WORD_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int REG_W    = 5;
  localparam int OPT_BITS = 6;

  localparam logic [WORD_W-1:0] ZERO_WORD = '0;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

  localparam logic [OPT_BITS-1:0] OPT_LUI   = 6'd1;
  localparam logic [OPT_BITS-1:0] OPT_AUIPC = 6'd2;
  localparam logic [OPT_BITS-1:0] OPT_JAL   = 6'd3;
  localparam logic [OPT_BITS-1:0] OPT_JALR  = 6'd4;
  localparam logic [OPT_BITS-1:0] OPT_BEQ   = 6'd5;
  localparam logic [OPT_BITS-1:0] OPT_BNE   = 6'd6;
  localparam logic [OPT_BITS-1:0] OPT_BLT   = 6'd7;
  localparam logic [OPT_BITS-1:0] OPT_BGE   = 6'd8;
  localparam logic [OPT_BITS-1:0] OPT_BLTU  = 6'd9;
  localparam logic [OPT_BITS-1:0] OPT_BGEU  = 6'd10;
  localparam logic [OPT_BITS-1:0] OPT_SB    = 6'd16;
  localparam logic [OPT_BITS-1:0] OPT_SH    = 6'd17;
  localparam logic [OPT_BITS-1:0] OPT_SW    = 6'd18;
  localparam logic [OPT_BITS-1:0] OPT_ADD   = 6'd19;

  typedef enum logic {ST_IDLE, ST_STORING} st_state_t;

  function automatic logic is_branch(input logic [OPT_BITS-1:0] opt);
    return opt inside {OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE, OPT_BLTU, OPT_BGEU};
  endfunction

  function automatic logic is_store(input logic [OPT_BITS-1:0] opt);
    return opt inside {OPT_SB, OPT_SH, OPT_SW};
  endfunction

  function automatic logic is_jalr(input logic [OPT_BITS-1:0] opt);
    return opt == OPT_JALR;
  endfunction

  // Opcodes whose result is fully known at decode.
  function automatic logic is_pre_ready(input logic [OPT_BITS-1:0] opt);
    return opt inside {OPT_LUI, OPT_AUIPC, OPT_JAL};
  endfunction

endpackage

// File: rtl/reorder_buffer_mc_fwd_mux.sv
// One operand query port: stored entry state overridden by a same-cycle writeback,
// highest channel winning. JALR entries keep their link value as the operand.
module rob_fwd_mux #(
  parameter int NUM_WB = 2,
  parameter int IDX_W  = 4
) (
  input  logic [IDX_W-1:0]             qry_idx,
  input  logic                         ent_rdy,
  input  logic                         ent_jalr,
  input  logic [31:0]                  ent_val,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB-1:0][IDX_W-1:0] wb_idx,
  input  logic [NUM_WB-1:0][31:0]      wb_val,
  output logic                         qry_rdy,
  output logic [31:0]                  qry_val
);

  always_comb begin
    qry_rdy = ent_rdy;
    qry_val = ent_val;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k] && wb_idx[k] == qry_idx) begin
        qry_rdy = 1'b1;
        qry_val = ent_jalr ? ent_val : wb_val[k];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer_mc.sv
// In-order-commit reorder buffer: allocate at tail, writeback by tag, retire head with
// registered 1-cycle commit, full flush on mispredict, stores retired via req/done.
module reorder_buffer_mc
  import reorder_buffer_mc_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int NUM_WB = 2,
  parameter int OPT_W  = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         stall_i,
  input  logic                         iss_valid,
  output logic                         iss_ready,
  output logic [IDX_W-1:0]             iss_idx,
  input  logic [OPT_W-1:0]             iss_opt,
  input  logic [REG_W-1:0]             iss_dest,
  input  logic [WORD_W-1:0]            iss_data,
  input  logic [ADDR_W-1:0]            iss_pc,
  input  logic [ADDR_W-1:0]            iss_mis_pc,
  input  logic                         iss_pb_tk,
  input  logic [ADDR_W-1:0]            iss_pred_tgt,
  input  logic [1:0][IDX_W-1:0]        qry_idx,
  output logic [1:0]                   qry_rdy,
  output logic [1:0][WORD_W-1:0]       qry_val,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB-1:0][IDX_W-1:0] wb_idx,
  input  logic [NUM_WB-1:0][31:0]      wb_val,
  input  logic [NUM_WB-1:0]            wb_tk,
  input  logic                         st_valid,
  input  logic [IDX_W-1:0]             st_idx,
  input  logic [ADDR_W-1:0]            st_addr,
  input  logic [WORD_W-1:0]            st_data,
  output logic                         reg_wr_ena,
  output logic [REG_W-1:0]             reg_wr_rd,
  output logic [WORD_W-1:0]            reg_wr_val,
  output logic [IDX_W-1:0]             reg_wr_idx,
  output logic                         mem_wr_req,
  output logic [ADDR_W-1:0]            mem_wr_addr,
  output logic [OPT_W-1:0]             mem_wr_opt,
  output logic [WORD_W-1:0]            mem_wr_data,
  input  logic                         mem_wr_done,
  output logic                         bp_fb_ena,
  output logic [ADDR_W-1:0]            bp_fb_pc,
  output logic                         bp_fb_tk,
  output logic                         flush_o,
  output logic [ADDR_W-1:0]            flush_pc
);

  logic [IDX_W-1:0]  head, tail;
  logic [IDX_W:0]    count;
  logic [DEPTH-1:0]  e_rdy, e_tk, e_pbtk;
  logic [OPT_W-1:0]  e_opt  [DEPTH];
  logic [REG_W-1:0]  e_dest [DEPTH];
  logic [WORD_W-1:0] e_val  [DEPTH];
  logic [ADDR_W-1:0] e_pc   [DEPTH];
  logic [ADDR_W-1:0] e_mis  [DEPTH];
  logic [ADDR_W-1:0] e_ptgt [DEPTH];
  logic [ADDR_W-1:0] e_tgt  [DEPTH];
  logic [ADDR_W-1:0] e_addr [DEPTH];
  st_state_t         st_state;
  logic              flush_pend;

  logic             freeze, push, pop, head_ok, alu_commit, st_start, st_done;
  logic [OPT_W-1:0] h_opt;

  assign freeze     = !rdy || stall_i;
  assign iss_ready  = count != (IDX_W+1)'(DEPTH);
  assign iss_idx    = tail;
  assign push       = iss_valid && iss_ready && !flush_pend;
  assign h_opt      = e_opt[head];
  // Entries behind a pending flush are wrong-path and must never retire.
  assign head_ok    = count != '0 && e_rdy[head] && !flush_pend;
  assign alu_commit = head_ok && st_state == ST_IDLE && !is_store(h_opt);
  assign st_start   = head_ok && st_state == ST_IDLE && is_store(h_opt);
  assign st_done    = st_state == ST_STORING && mem_wr_done;
  assign pop        = alu_commit || st_done;

  for (genvar q = 0; q < 2; q++) begin : g_qry
    rob_fwd_mux #(.NUM_WB(NUM_WB), .IDX_W(IDX_W)) u_fwd (
      .qry_idx (qry_idx[q]),
      .ent_rdy (e_rdy[qry_idx[q]]),
      .ent_jalr(is_jalr(e_opt[qry_idx[q]])),
      .ent_val (e_val[qry_idx[q]]),
      .wb_valid(wb_valid),
      .wb_idx  (wb_idx),
      .wb_val  (wb_val),
      .qry_rdy (qry_rdy[q]),
      .qry_val (qry_val[q])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0; tail <= '0; count <= '0; e_rdy <= '0;
      st_state <= ST_IDLE; flush_pend <= 1'b0;
      reg_wr_ena <= 1'b0; reg_wr_rd <= '0; reg_wr_val <= ZERO_WORD; reg_wr_idx <= '0;
      mem_wr_req <= 1'b0; mem_wr_addr <= ZERO_ADDR; mem_wr_opt <= '0; mem_wr_data <= ZERO_WORD;
      bp_fb_ena <= 1'b0; bp_fb_pc <= ZERO_ADDR; bp_fb_tk <= 1'b0;
      flush_o <= 1'b0; flush_pc <= ZERO_ADDR;
    end else if (freeze) begin
      reg_wr_ena <= 1'b0;
      bp_fb_ena  <= 1'b0;
      flush_o    <= 1'b0;
    end else begin
      reg_wr_ena <= 1'b0;
      bp_fb_ena  <= 1'b0;
      flush_o    <= 1'b0;
      if (flush_pend) begin
        head <= '0; tail <= '0; count <= '0; e_rdy <= '0;
        flush_pend <= 1'b0;
      end else begin
        if (push) begin
          e_opt[tail]  <= iss_opt;
          e_dest[tail] <= iss_dest;
          e_val[tail]  <= iss_data;
          e_pc[tail]   <= iss_pc;
          e_mis[tail]  <= iss_mis_pc;
          e_pbtk[tail] <= iss_pb_tk;
          e_ptgt[tail] <= iss_pred_tgt;
          e_rdy[tail]  <= is_pre_ready(iss_opt);
          tail         <= tail + 1'b1;
        end
        for (int k = 0; k < NUM_WB; k++) begin
          if (wb_valid[k]) begin
            e_rdy[wb_idx[k]] <= 1'b1;
            if (is_jalr(e_opt[wb_idx[k]])) begin
              e_tgt[wb_idx[k]] <= wb_val[k];
            end else begin
              e_val[wb_idx[k]] <= wb_val[k];
              e_tk[wb_idx[k]]  <= wb_tk[k];
            end
          end
        end
        if (st_valid) begin
          e_addr[st_idx] <= st_addr;
          e_val[st_idx]  <= st_data;
          e_rdy[st_idx]  <= 1'b1;
        end
        if (st_start) begin
          mem_wr_req  <= 1'b1;
          mem_wr_addr <= e_addr[head];
          mem_wr_opt  <= h_opt;
          mem_wr_data <= e_val[head];
          st_state    <= ST_STORING;
        end
        if (st_done) begin
          mem_wr_req <= 1'b0;
          st_state   <= ST_IDLE;
        end
        if (alu_commit) begin
          if (is_branch(h_opt)) begin
            bp_fb_ena <= 1'b1;
            bp_fb_pc  <= e_pc[head];
            bp_fb_tk  <= e_tk[head];
            if (e_tk[head] != e_pbtk[head]) begin
              flush_o    <= 1'b1;
              flush_pc   <= e_mis[head];
              flush_pend <= 1'b1;
            end
          end else begin
            reg_wr_ena <= 1'b1;
            reg_wr_rd  <= e_dest[head];
            reg_wr_val <= e_val[head];
            reg_wr_idx <= head;
            if (is_jalr(h_opt) && e_tgt[head] != e_ptgt[head]) begin
              flush_o    <= 1'b1;
              flush_pc   <= e_tgt[head];
              flush_pend <= 1'b1;
            end
          end
        end
        if (pop) head <= head + 1'b1;
        count <= count + (IDX_W+1)'(push) - (IDX_W+1)'(pop);
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Directed stimulus with a queue scoreboard; a negedge monitor checks every retire-side output.
module tb_reorder_buffer_mc;
  import reorder_buffer_mc_pkg::*;

  logic clk, rst, rdy, stall_i;
  logic iss_valid, iss_ready;
  logic [3:0] iss_idx;
  logic [5:0] iss_opt;
  logic [4:0] iss_dest;
  logic [31:0] iss_data, iss_pc, iss_mis_pc, iss_pred_tgt;
  logic iss_pb_tk;
  logic [1:0][3:0] qry_idx;
  logic [1:0] qry_rdy;
  logic [1:0][31:0] qry_val;
  logic [1:0] wb_valid, wb_tk;
  logic [1:0][3:0] wb_idx;
  logic [1:0][31:0] wb_val;
  logic st_valid;
  logic [3:0] st_idx;
  logic [31:0] st_addr, st_data;
  logic reg_wr_ena;
  logic [4:0] reg_wr_rd;
  logic [31:0] reg_wr_val;
  logic [3:0] reg_wr_idx;
  logic mem_wr_req, mem_wr_done;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic [5:0] mem_wr_opt;
  logic bp_fb_ena, bp_fb_tk, flush_o;
  logic [31:0] bp_fb_pc, flush_pc;

  reorder_buffer_mc #(.DEPTH(16), .IDX_W(4), .NUM_WB(2), .OPT_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_i(stall_i),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_idx(iss_idx), .iss_opt(iss_opt),
    .iss_dest(iss_dest), .iss_data(iss_data), .iss_pc(iss_pc), .iss_mis_pc(iss_mis_pc),
    .iss_pb_tk(iss_pb_tk), .iss_pred_tgt(iss_pred_tgt),
    .qry_idx(qry_idx), .qry_rdy(qry_rdy), .qry_val(qry_val),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_val(wb_val), .wb_tk(wb_tk),
    .st_valid(st_valid), .st_idx(st_idx), .st_addr(st_addr), .st_data(st_data),
    .reg_wr_ena(reg_wr_ena), .reg_wr_rd(reg_wr_rd), .reg_wr_val(reg_wr_val), .reg_wr_idx(reg_wr_idx),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_opt(mem_wr_opt),
    .mem_wr_data(mem_wr_data), .mem_wr_done(mem_wr_done),
    .bp_fb_ena(bp_fb_ena), .bp_fb_pc(bp_fb_pc), .bp_fb_tk(bp_fb_tk),
    .flush_o(flush_o), .flush_pc(flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] val; logic [3:0] idx; } reg_exp_t;
  typedef struct { logic [31:0] pc; logic tk; } bp_exp_t;
  typedef struct { logic [31:0] addr; logic [5:0] opt; logic [31:0] data; } st_exp_t;

  reg_exp_t    exp_reg[$];
  bp_exp_t     exp_bp[$];
  logic [31:0] exp_fl[$];
  st_exp_t     exp_st[$];

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input int k, input logic [3:0] idx, input logic [31:0] val, input logic tk);
    wb_valid[k] = 1'b1;
    wb_idx[k]   = idx;
    wb_val[k]   = val;
    wb_tk[k]    = tk;
  endtask

  task automatic wb(input int k, input logic [3:0] idx, input logic [31:0] val, input logic tk);
    set_wb(k, idx, val, tk);
    tick();
    wb_valid = '0;
  endtask

  task automatic issue(input logic [5:0] opt, input logic [4:0] rd, input logic [31:0] data,
                       input logic [31:0] pc, input logic [31:0] mis, input logic [31:0] ptgt,
                       input logic pbtk, input logic [3:0] exp_idx);
    iss_valid = 1'b1; iss_opt = opt; iss_dest = rd; iss_data = data; iss_pc = pc;
    iss_mis_pc = mis; iss_pred_tgt = ptgt; iss_pb_tk = pbtk;
    #1;
    chk("iss_idx", 32'(iss_idx), 32'(exp_idx));
    chk("iss_ready_on_issue", 32'(iss_ready), 1);
    tick();
    iss_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_reg.size() + exp_bp.size() + exp_fl.size() + exp_st.size()) != 0 && n < 100) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk({name, "_pending_left"}, 32'(exp_reg.size() + exp_bp.size() + exp_fl.size() + exp_st.size()), 0);
  endtask

  task automatic wait_flush(input string name);
    int n = 0;
    while (!flush_o && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_flush_seen"}, 32'(flush_o), 1);
    tick();
    chk({name, "_post_flush_count"}, 32'(dut.count), 0);
    chk({name, "_post_flush_iss_idx"}, 32'(iss_idx), 0);
    chk({name, "_post_flush_iss_ready"}, 32'(iss_ready), 1);
  endtask

  // Scoreboard monitor
  reg_exp_t m_reg;
  bp_exp_t  m_bp;
  st_exp_t  m_st;
  logic [31:0] m_fl;
  logic prev_req = 1'b0;
  logic [31:0] l_addr, l_data;
  logic [5:0]  l_opt;

  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wr_ena) begin
        if (exp_reg.size() == 0) chk("reg_wr_unexpected", 1, 0);
        else begin
          m_reg = exp_reg.pop_front();
          chk("reg_wr_rd", 32'(reg_wr_rd), 32'(m_reg.rd));
          chk("reg_wr_val", reg_wr_val, m_reg.val);
          chk("reg_wr_idx", 32'(reg_wr_idx), 32'(m_reg.idx));
        end
      end
      if (bp_fb_ena) begin
        if (exp_bp.size() == 0) chk("bp_fb_unexpected", 1, 0);
        else begin
          m_bp = exp_bp.pop_front();
          chk("bp_fb_pc", bp_fb_pc, m_bp.pc);
          chk("bp_fb_tk", 32'(bp_fb_tk), 32'(m_bp.tk));
        end
      end
      if (flush_o) begin
        if (exp_fl.size() == 0) chk("flush_unexpected", 1, 0);
        else begin
          m_fl = exp_fl.pop_front();
          chk("flush_pc", flush_pc, m_fl);
        end
      end
      if (mem_wr_req && !prev_req) begin
        if (exp_st.size() == 0) chk("mem_wr_unexpected", 1, 0);
        else begin
          m_st = exp_st.pop_front();
          chk("mem_wr_addr", mem_wr_addr, m_st.addr);
          chk("mem_wr_opt", 32'(mem_wr_opt), 32'(m_st.opt));
          chk("mem_wr_data", mem_wr_data, m_st.data);
          l_addr = m_st.addr; l_opt = m_st.opt; l_data = m_st.data;
        end
      end else if (mem_wr_req) begin
        chk("mem_wr_addr_stable", mem_wr_addr, l_addr);
        chk("mem_wr_opt_stable", 32'(mem_wr_opt), 32'(l_opt));
        chk("mem_wr_data_stable", mem_wr_data, l_data);
      end
      prev_req = mem_wr_req;
    end
  end

  always @(posedge clk) begin
    if (!rst) assert (!(wb_valid == 2'b11 && wb_idx[0] == wb_idx[1]))
      else $error("two writeback channels target one entry");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; stall_i = 1'b0;
    iss_valid = 1'b0; iss_opt = '0; iss_dest = '0; iss_data = '0; iss_pc = '0;
    iss_mis_pc = '0; iss_pred_tgt = '0; iss_pb_tk = 1'b0;
    qry_idx = '0; wb_valid = '0; wb_idx = '0; wb_val = '0; wb_tk = '0;
    st_valid = 1'b0; st_idx = '0; st_addr = '0; st_data = '0; mem_wr_done = 1'b0;
    repeat (3) tick();
    chk("rst_iss_ready", 32'(iss_ready), 1);
    chk("rst_iss_idx", 32'(iss_idx), 0);
    chk("rst_reg_wr_ena", 32'(reg_wr_ena), 0);
    chk("rst_mem_wr_req", 32'(mem_wr_req), 0);
    chk("rst_flush_o", 32'(flush_o), 0);
    chk("rst_bp_fb_ena", 32'(bp_fb_ena), 0);
    rst = 1'b0;

    // Fill to full, then write back in reverse order.
    for (int i = 0; i < 16; i++) begin
      exp_reg.push_back('{5'(i + 1), 32'h1000 + 32'(i), 4'(i)});
      issue(OPT_ADD, 5'(i + 1), 32'h0, 32'(4 * i), 32'h0, 32'h0, 1'b0, 4'(i));
    end
    chk("full_iss_ready", 32'(iss_ready), 0);
    qry_idx[0] = 4'd3;
    #1;
    chk("qry_not_ready", 32'(qry_rdy[0]), 0);
    for (int i = 15; i >= 0; i--) begin
      wb(0, 4'(i), 32'h1000 + 32'(i), 1'b0);
      if (i == 15) begin
        qry_idx[0] = 4'd15;
        #1;
        chk("qry_stored_rdy", 32'(qry_rdy[0]), 1);
        chk("qry_stored_val", qry_val[0], 32'h100F);
      end
    end
    drain("fill");
    chk("fill_iss_idx_wrapped", 32'(iss_idx), 0);
    chk("fill_iss_ready", 32'(iss_ready), 1);

    // Move head to 14 with pre-ready LUIs, then push 4 / commit 2 across the wrap.
    for (int i = 0; i < 14; i++) begin
      exp_reg.push_back('{5'd20, 32'h5000 + 32'(i), 4'(i)});
      issue(OPT_LUI, 5'd20, 32'h5000 + 32'(i), 32'h0, 32'h0, 32'h0, 1'b0, 4'(i));
    end
    drain("lui");
    chk("lui_iss_idx", 32'(iss_idx), 14);
    exp_reg.push_back('{5'd21, 32'hA1, 4'd14});
    exp_reg.push_back('{5'd22, 32'hB2, 4'd15});
    exp_reg.push_back('{5'd23, 32'hC3, 4'd0});
    exp_reg.push_back('{5'd24, 32'hD4, 4'd1});
    issue(OPT_ADD, 5'd21, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd14);
    set_wb(0, 4'd14, 32'hA1, 1'b0);
    issue(OPT_ADD, 5'd22, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd15);
    wb_valid = '0;
    set_wb(0, 4'd15, 32'hB2, 1'b0);
    issue(OPT_ADD, 5'd23, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0);
    wb_valid = '0;
    issue(OPT_ADD, 5'd24, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd1);
    chk("wrap_count", 32'(dut.count), 2);
    chk("wrap_iss_ready", 32'(iss_ready), 1);
    wb(0, 4'd0, 32'hC3, 1'b0);
    wb(0, 4'd1, 32'hD4, 1'b0);
    drain("wrap");
    chk("wrap_iss_idx", 32'(iss_idx), 2);
    chk("wrap_count_empty", 32'(dut.count), 0);

    // Branch mispredict: predicted taken, resolved not taken.
    exp_bp.push_back('{32'h100, 1'b0});
    exp_fl.push_back(32'h104);
    issue(OPT_BEQ, 5'd0, 32'h0, 32'h100, 32'h104, 32'h0, 1'b1, 4'd2);
    issue(OPT_ADD, 5'd5, 32'h0, 32'h104, 32'h0, 32'h0, 1'b0, 4'd3);
    wb(1, 4'd2, 32'h0, 1'b0);
    wait_flush("br");

    // JALR mispredict, then correctly predicted JALR.
    exp_reg.push_back('{5'd1, 32'h208, 4'd0});
    exp_fl.push_back(32'h400);
    issue(OPT_JALR, 5'd1, 32'h208, 32'h204, 32'h0, 32'h300, 1'b0, 4'd0);
    qry_idx[1] = 4'd0;
    set_wb(0, 4'd0, 32'h400, 1'b0);
    #1;
    chk("jalr_qry_fwd_rdy", 32'(qry_rdy[1]), 1);
    chk("jalr_qry_fwd_val", qry_val[1], 32'h208);
    tick();
    wb_valid = '0;
    wait_flush("jalr");
    exp_reg.push_back('{5'd1, 32'h208, 4'd0});
    issue(OPT_JALR, 5'd1, 32'h208, 32'h204, 32'h0, 32'h400, 1'b0, 4'd0);
    wb(0, 4'd0, 32'h400, 1'b0);
    drain("jalr_ok");
    chk("jalr_ok_iss_idx", 32'(iss_idx), 1);

    // Store at head with a slow done; younger ALU op behind it.
    exp_st.push_back('{32'h80, OPT_SW, 32'hDEAD});
    exp_reg.push_back('{5'd7, 32'h77, 4'd2});
    issue(OPT_SW, 5'd0, 32'h0, 32'h300, 32'h0, 32'h0, 1'b0, 4'd1);
    issue(OPT_ADD, 5'd7, 32'h0, 32'h304, 32'h0, 32'h0, 1'b0, 4'd2);
    st_valid = 1'b1; st_idx = 4'd1; st_addr = 32'h80; st_data = 32'hDEAD;
    wb(0, 4'd2, 32'h77, 1'b0);
    st_valid = 1'b0;
    begin
      int n = 0;
      while (!mem_wr_req && n < 20) begin
        tick();
        n++;
      end
    end
    chk("st_req_raised", 32'(mem_wr_req), 1);
    repeat (3) begin
      tick();
      chk("st_req_held", 32'(mem_wr_req), 1);
      chk("st_no_commit_while_storing", 32'(reg_wr_ena), 0);
    end
    mem_wr_done = 1'b1;
    tick();
    mem_wr_done = 1'b0;
    chk("st_req_dropped", 32'(mem_wr_req), 0);
    chk("st_count_after_pop", 32'(dut.count), 1);
    tick();
    chk("st_younger_commit_next", 32'(reg_wr_ena), 1);
    chk("st_req_stays_low", 32'(mem_wr_req), 0);
    drain("store");

    // Same-cycle forward on channel 1 while frozen; the frozen writeback must be dropped.
    exp_reg.push_back('{5'd9, 32'h99, 4'd3});
    issue(OPT_ADD, 5'd9, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd3);
    wb(0, 4'd3, 32'h99, 1'b0);
    stall_i = 1'b1;
    qry_idx[0] = 4'd5;
    qry_idx[1] = 4'd3;
    set_wb(1, 4'd5, 32'hAB, 1'b0);
    #1;
    chk("qry_fwd_rdy", 32'(qry_rdy[0]), 1);
    chk("qry_fwd_val", qry_val[0], 32'hAB);
    chk("qry_entry3_rdy", 32'(qry_rdy[1]), 1);
    chk("qry_entry3_val", qry_val[1], 32'h99);
    repeat (3) begin
      tick();
      chk("stall_no_commit", 32'(reg_wr_ena), 0);
      chk("stall_count_held", 32'(dut.count), 1);
    end
    wb_valid = '0;
    #1;
    chk("stall_wb_ignored", 32'(qry_rdy[0]), 0);
    stall_i = 1'b0;
    rdy = 1'b0;
    tick();
    chk("rdy_low_no_commit", 32'(reg_wr_ena), 0);
    rdy = 1'b1;
    drain("stall");
    chk("final_iss_idx", 32'(iss_idx), 4);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
